// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with req/ack imem port, skid buffer, jump redirect and IF/ID register
// Ports: clk/rst (sync, active-high); stall/flush/pc_jump/jump_target from hazard and branch logic;
// imem_req/imem_addr/imem_ack/imem_rdata instruction memory handshake;
// ifid_instr/ifid_pc4/ifid_valid IF/ID register; opcode/func decoded fields of ifid_instr.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, skid_q, skid_d, redir_q, redir_d, pc_inc;
  logic valid_q, valid_d;
  assign pc_inc = pc_q + PC_INC;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    skid_d  = skid_q;
    redir_d = redir_q;
    if (pc_jump) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      skid_d  = NOP_WORD;
      // An unacknowledged request must keep its address, so park the target until the ack drains it.
      if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_ack) begin
        redir_d = jump_target;
        state_d = S_DRAIN;
      end else begin
        pc_d    = jump_target;
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_BOOT: state_d = S_FETCH;
        S_FETCH: if (imem_ack) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
        S_HOLD: if (!stall) begin
          instr_d = skid_q;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
        default: if (imem_ack) begin
          pc_d    = redir_q;
          state_d = S_FETCH;
        end
      endcase
      if (flush) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      skid_q  <= NOP_WORD;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
      redir_q <= redir_d;
    end
  end
  assign imem_req   = state_q == S_FETCH || state_q == S_DRAIN;
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign opcode     = instr_q[31:26];
  assign func       = instr_q[5:0];
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the MIPS pipeline. Holds the PC and drives a request/acknowledge instruction-memory port. Captures each fetched word with its PC+4 into the IF/ID register, whose opcode/func fields feed the decode controller directly. Handles stall from the hazard unit and jump redirect/flush, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment per sequential fetch
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold IF/ID contents and PC; from hazard unit
flush  input  1  replace IF/ID with bubble next edge
pc_jump  input  1  redirect PC to jump_target (implies flush)
jump_target  input  32  redirect address, sampled when pc_jump=1
imem_req  output  1  instruction memory request
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  one-cycle pulse, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
ifid_instr  output  32  registered instruction
ifid_pc4  output  32  registered PC+PC_INC of that instruction
ifid_valid  output  1  IF/ID holds a real instruction
opcode  output  6  ifid_instr[31:26], combinational from register
func  output  6  ifid_instr[5:0], combinational from register

Behaviour:
- Reset (rst=1 at edge, overrides all): pc<=RESET_PC; state<=S_BOOT; ifid_instr<=NOP_WORD; ifid_pc4<=0; ifid_valid<=0; redirect_pending<=0; skid empty. imem_req=0 during and one cycle after reset.
- States: S_BOOT, S_FETCH, S_HOLD, S_DRAIN.
- S_BOOT: imem_req=0; next edge -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc. Without ack, stay.
  - On ack with stall=0: IF/ID<={imem_rdata, pc+PC_INC, valid=1}; pc<=pc+PC_INC; stay. Back-to-back fetch, one instruction per cycle when memory acks same cycle.
  - On ack with stall=1: word and pc+PC_INC go to a one-entry skid buffer; IF/ID unchanged; -> S_HOLD.
- S_HOLD: imem_req=0. When stall=0: IF/ID<=skid (valid=1), pc<=pc+PC_INC, skid cleared, -> S_FETCH.
- Redirect (pc_jump=1), priority below rst, above stall:
  - IF/ID<=bubble (NOP_WORD, valid=0) regardless of stall; skid discarded.
  - If in S_FETCH with no ack this cycle: address must stay stable, so latch jump_target into redirect_pending and go to S_DRAIN; S_DRAIN keeps imem_req=1 with the old imem_addr; on ack discard the data, pc<=pending target, -> S_FETCH.
  - Otherwise (ack this cycle, S_HOLD, S_BOOT): pc<=jump_target; discard any ack data; -> S_FETCH.
  - pc_jump in S_DRAIN: overwrite the pending target (last one wins).
- flush=1 without pc_jump: IF/ID<=bubble; PC, skid and FSM unaffected.
- stall=1 alone: IF/ID and pc hold. An ack arriving during stall is never lost: it goes to the skid buffer.
- flush and stall together: flush wins for IF/ID; stall still governs PC and skid.
- Arithmetic: pc+PC_INC is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- opcode/func follow ifid_instr and are 0 while a bubble is held.

Test Plan:
- Reset then memory acking each request in the same cycle with words W0..W3: imem_addr 0,4,8,12; ifid_instr=W0..W3 on consecutive cycles; ifid_pc4=4,8,12,16; valid=1.
- stall=1 for 3 cycles with ack arriving in the first: IF/ID unchanged, imem_req=0 in S_HOLD; after release IF/ID=skid word and the next imem_addr is PC+4. No word dropped or duplicated.
- pc_jump=1, jump_target=32'h0000_0400, with no request outstanding: next cycle ifid_valid=0 and instr=0; following fetch imem_addr=0x400.
- pc_jump while a request to 0x10 is pending, ack delayed 3 cycles: imem_addr stays 0x10 until ack; ack data is not written to IF/ID; next request is 0x400.
- RESET_PC=32'hFFFF_FFFC: first fetch at 0xFFFFFFFC; ifid_pc4=0; second fetch at 0x0.
- rst asserted mid-S_DRAIN and while in S_HOLD: next cycle all outputs are at reset values, imem_req=0 for one cycle, then fetch from RESET_PC.
